// File: rtl/fft_spi_pkg.sv
// Shared defaults and FSM state type for the FFT result SPI transmitter.
// FFT_SPI_WORD_CS_EN adds the GAP state used for per-word chip-select windows.
package fft_spi_pkg;

  localparam int DATA_W_DEF  = 256;
  localparam int WORD_W_DEF  = 16;
  localparam int CLK_DIV_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOW   = 3'd1,
    ST_HIGH  = 3'd2,
    ST_TRAIL = 3'd3
`ifdef FFT_SPI_WORD_CS_EN
    ,
    ST_GAP   = 3'd4
`endif
  } spi_state_t;

endpackage

// File: rtl/fft_result_spi_tx_if.sv
// Frame input and SPI pin bundle between the FFT core, the transmitter and the board.
// master is the transmitter side; slave is the FFT core / pin side.
interface fft_result_spi_tx_if
  import fft_spi_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic [DATA_W-1:0] data_bus;
  logic              start_spi;
  logic              sclk;
  logic              mosi;
  logic              cs;
  logic              busy;
  logic              done;

  modport master (
    input  data_bus, start_spi,
    output sclk, mosi, cs, busy, done
  );

  modport slave (
    output data_bus, start_spi,
    input  sclk, mosi, cs, busy, done
  );

endinterface

// File: rtl/spi_clk_div.sv
// Divides the system clock into CLK_DIV-cycle phases for the SPI FSM.
// phase_tick_o marks the last cycle of each phase while en_i is high.
module spi_clk_div
  import fft_spi_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic phase_tick_o
);

  localparam int               CNT_W    = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every combinational output gets a default before any branch so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign phase_tick_o = en_i && (cnt_q == CNT_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fft_result_spi_tx.sv
// Mode-0 SPI master: latches one FFT result frame and shifts it out MSB first.
// Define FFT_SPI_WORD_CS_EN to raise cs for CLK_DIV cycles between words.
module fft_result_spi_tx
  import fft_spi_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int WORD_W  = WORD_W_DEF,
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic                clk,
  input  logic                rst,
  fft_result_spi_tx_if.master spi
);

  localparam int                   BIT_CNT_W = $clog2(DATA_W + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(DATA_W - 1);

  if ((DATA_W % WORD_W) != 0 || CLK_DIV < 1) begin : g_bad_cfg
    $error("fft_result_spi_tx: DATA_W must be a multiple of WORD_W and CLK_DIV >= 1");
  end

  spi_state_t             state_q, state_d;
  logic [DATA_W-1:0]      shift_q, shift_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic                   sclk_q, sclk_d;
  logic                   mosi_q, mosi_d;
  logic                   cs_q, cs_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   div_en;
  logic                   phase_tick;

  assign div_en = (state_q != ST_IDLE);

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk          (clk),
    .rst          (rst),
    .en_i         (div_en),
    .phase_tick_o (phase_tick)
  );

`ifdef FFT_SPI_WORD_CS_EN
  logic word_end;
  assign word_end = ((32'(bit_cnt_q) % WORD_W) == (WORD_W - 1));
`endif

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_d      = cs_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      // The done cycle itself is still IDLE, so a start there is refused.
      ST_IDLE: begin
        if (spi.start_spi && !done_q) begin
          shift_d   = spi.data_bus;
          bit_cnt_d = '0;
          mosi_d    = spi.data_bus[DATA_W-1];
          sclk_d    = 1'b0;
          cs_d      = 1'b0;
          busy_d    = 1'b1;
          state_d   = ST_LOW;
        end
      end

      ST_LOW: begin
        if (phase_tick) begin
          sclk_d  = 1'b1;
          state_d = ST_HIGH;
        end
      end

      ST_HIGH: begin
        if (phase_tick) begin
          sclk_d = 1'b0;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = ST_TRAIL;
          end else begin
            shift_d   = shift_q << 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
`ifdef FFT_SPI_WORD_CS_EN
            if (word_end) begin
              cs_d    = 1'b1;
              mosi_d  = 1'b0;
              state_d = ST_GAP;
            end else begin
              mosi_d  = shift_q[DATA_W-2];
              state_d = ST_LOW;
            end
`else
            mosi_d  = shift_q[DATA_W-2];
            state_d = ST_LOW;
`endif
          end
        end
      end

      ST_TRAIL: begin
        if (phase_tick) begin
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

`ifdef FFT_SPI_WORD_CS_EN
      // Shift register already holds the next word, so its MSB goes out with cs.
      ST_GAP: begin
        if (phase_tick) begin
          cs_d    = 1'b0;
          mosi_d  = shift_q[DATA_W-1];
          state_d = ST_LOW;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      // NOTE: the frame shift register is cleared on reset so no stale data is ever observable.
      shift_q   <= '0;
      bit_cnt_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_q      <= cs_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign spi.sclk = sclk_q;
  assign spi.mosi = mosi_q;
  assign spi.cs   = cs_q;
  assign spi.busy = busy_q;
  assign spi.done = done_q;

endmodule

// File: tb/tb_fft_result_spi_tx.sv
// Self-checking bench for fft_result_spi_tx: scoreboard of expected bits per rising sclk,
// frame timing counters, reset abort, back-to-back restart and a CLK_DIV=1 instance.
`timescale 1ns/1ps
module tb_fft_result_spi_tx;

  localparam int DW  = fft_spi_pkg::DATA_W_DEF;
  localparam int WW  = fft_spi_pkg::WORD_W_DEF;
  localparam int CD0 = 4;
  localparam int CD1 = 1;
`ifdef FFT_SPI_WORD_CS_EN
  localparam int WIN_RISES = WW;
  localparam int N_WIN     = DW / WW;
`else
  localparam int WIN_RISES = DW;
  localparam int N_WIN     = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_result_spi_tx_if #(.DATA_W(DW)) bus0 ();
  fft_result_spi_tx_if #(.DATA_W(DW)) bus1 ();

  fft_result_spi_tx #(.DATA_W(DW), .WORD_W(WW), .CLK_DIV(CD0)) dut (
    .clk (clk),
    .rst (rst),
    .spi (bus0.master)
  );

  fft_result_spi_tx #(.DATA_W(DW), .WORD_W(WW), .CLK_DIV(CD1)) dut1 (
    .clk (clk),
    .rst (rst),
    .spi (bus1.master)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboards and monitors: one bit is popped per observed rising sclk.
  logic q0[$];
  logic q1[$];
  logic exp0, exp1;
  int   rises0, cs_low0, done0, done_rise0, windows0, win_bad0, gap_bad0, gap_run0, win_rises0;
  int   rises1, cs_low1, done1;
  logic prev_sclk0 = 1'b0, prev_cs0 = 1'b1, prev_sclk1 = 1'b0;

  always @(negedge clk) begin
    if (!bus0.cs && prev_cs0) begin
      windows0++;
      if (gap_run0 != 0 && gap_run0 != CD0) gap_bad0++;
      gap_run0   = 0;
      win_rises0 = 0;
    end
    if (bus0.cs && !prev_cs0 && win_rises0 != WIN_RISES) win_bad0++;
    if (bus0.sclk && !prev_sclk0) begin
      rises0++;
      win_rises0++;
      if (q0.size() == 0) check("bit0_extra", 32'(q0.size()), 32'd1);
      else begin
        exp0 = q0.pop_front();
        check("bit0", 32'(bus0.mosi), 32'(exp0));
      end
    end
    if (!bus0.cs) cs_low0++;
    if (bus0.cs && bus0.busy) gap_run0++;
    if (bus0.done) begin
      done0++;
      if (bus0.cs && !prev_cs0) done_rise0++;
    end
    prev_sclk0 = bus0.sclk;
    prev_cs0   = bus0.cs;
  end

  always @(negedge clk) begin
    if (bus1.sclk && !prev_sclk1) begin
      rises1++;
      if (q1.size() == 0) check("bit1_extra", 32'(q1.size()), 32'd1);
      else begin
        exp1 = q1.pop_front();
        check("bit1", 32'(bus1.mosi), 32'(exp1));
      end
    end
    if (!bus1.cs) cs_low1++;
    if (bus1.done) done1++;
    prev_sclk1 = bus1.sclk;
  end

  task automatic clear0();
    rises0 = 0; cs_low0 = 0; done0 = 0; done_rise0 = 0; windows0 = 0;
    win_bad0 = 0; gap_bad0 = 0; gap_run0 = 0; win_rises0 = 0;
    q0.delete();
  endtask

  task automatic clear1();
    rises1 = 0; cs_low1 = 0; done1 = 0;
    q1.delete();
  endtask

  task automatic push_frame(input bit which, input logic [DW-1:0] d);
    for (int i = DW - 1; i >= 0; i--) begin
      if (which) q1.push_back(d[i]);
      else       q0.push_back(d[i]);
    end
  endtask

  // Returns #1 after the accept edge when hold == 1.
  task automatic start_frame(input bit which, input logic [DW-1:0] d, input int hold);
    @(posedge clk); #1;
    if (which) begin bus1.data_bus = d; bus1.start_spi = 1'b1; end
    else       begin bus0.data_bus = d; bus0.start_spi = 1'b1; end
    repeat (hold) @(posedge clk);
    #1;
    if (which) bus1.start_spi = 1'b0;
    else       bus0.start_spi = 1'b0;
  endtask

  task automatic wait_done(input bit which, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk); #1;
      ok = which ? bus1.done : bus0.done;
    end
  endtask

  task automatic frame_check0(input string tag);
    check({tag, "_rises"},     32'(rises0),     32'(DW));
    check({tag, "_cs_low"},    32'(cs_low0),    32'(CD0 * (2 * DW + 1)));
    check({tag, "_done_cnt"},  32'(done0),      32'd1);
    check({tag, "_done_cs"},   32'(done_rise0), 32'd1);
    check({tag, "_windows"},   32'(windows0),   32'(N_WIN));
    check({tag, "_win_bits"},  32'(win_bad0),   32'd0);
    check({tag, "_gap_len"},   32'(gap_bad0),   32'd0);
    check({tag, "_sb_empty"},  32'(q0.size()),  32'd0);
  endtask

  function automatic logic [DW-1:0] rand_bus();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  logic [DW-1:0] pat;
  bit            ok;
  int            bad;
  int            n;

  initial begin
    bus0.start_spi = 1'b0; bus0.data_bus = '0;
    bus1.start_spi = 1'b0; bus1.data_bus = '0;
    clear0();
    clear1();

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_cs",   32'(bus0.cs),   32'd1);
    check("rst_sclk", 32'(bus0.sclk), 32'd0);
    check("rst_mosi", 32'(bus0.mosi), 32'd0);
    check("rst_busy", 32'(bus0.busy), 32'd0);
    check("rst_done", 32'(bus0.done), 32'd0);
    check("rst_cs1",  32'(bus1.cs),   32'd1);
    @(posedge clk); #1 rst = 1'b0;

    // Idle with no start
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bus0.cs !== 1'b1 || bus0.sclk !== 1'b0 || bus0.mosi !== 1'b0 ||
          bus0.busy !== 1'b0 || bus0.done !== 1'b0) bad++;
    end
    check("idle_hold",  32'(bad),    32'd0);
    check("idle_rises", 32'(rises0), 32'd0);

    // Frame A: fixed pattern, data change and start pulse mid-frame
    pat = {16'h8000, 16'h0001, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'hFFFF, 16'h0000,
           16'hAAAA, 16'h5555, 16'h0F0F, 16'hF0F0, 16'hC3C3, 16'h3C3C, 16'h7E81, 16'hA5A5};
    clear0();
    push_frame(1'b0, pat);
    start_frame(1'b0, pat, 1);
    check("a_accept_cs",   32'(bus0.cs),   32'd0);
    check("a_accept_busy", 32'(bus0.busy), 32'd1);
    check("a_accept_mosi", 32'(bus0.mosi), 32'd1);
    check("a_accept_sclk", 32'(bus0.sclk), 32'd0);
    repeat (300) @(posedge clk);
    start_frame(1'b0, ~pat, 1);
    check("a_busy_mid", 32'(bus0.busy), 32'd1);
    wait_done(1'b0, 5000, ok);
    check("a_done_seen", 32'(ok), 32'd1);
    frame_check0("a");
    repeat (3000) @(negedge clk);
    check("a_no_second_rises", 32'(rises0),  32'(DW));
    check("a_no_second_done",  32'(done0),   32'd1);
    check("a_idle_cs",         32'(bus0.cs), 32'd1);

    // Frame B: reset at bit 100 aborts without done
    clear0();
    pat = rand_bus();
    push_frame(1'b0, pat);
    start_frame(1'b0, pat, 1);
    n = 0;
    while (rises0 < 100 && n < 5000) begin
      @(negedge clk); #1;
      n++;
    end
    check("b_reach_bit100", 32'(rises0), 32'd100);
    rst = 1'b1;
    #1;
    check("b_abort_cs",   32'(bus0.cs),   32'd1);
    check("b_abort_sclk", 32'(bus0.sclk), 32'd0);
    check("b_abort_busy", 32'(bus0.busy), 32'd0);
    check("b_abort_mosi", 32'(bus0.mosi), 32'd0);
    repeat (5) @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    check("b_no_done", 32'(done0), 32'd0);

    // Frame C: full frame after the abort
    clear0();
    pat = rand_bus();
    push_frame(1'b0, pat);
    start_frame(1'b0, pat, 1);
    wait_done(1'b0, 5000, ok);
    check("c_done_seen", 32'(ok), 32'd1);
    frame_check0("c");

    // Frames D/E: start held through the done cycle; accepted only the cycle after
    clear0();
    pat = rand_bus();
    push_frame(1'b0, pat);
    start_frame(1'b0, pat, 1);
    wait_done(1'b0, 5000, ok);
    check("d_done_seen", 32'(ok), 32'd1);
    frame_check0("d");
    clear0();
    bus0.data_bus  = '0;
    bus0.start_spi = 1'b1;
    pat = rand_bus();
    pat[DW-1] = 1'b1;
    push_frame(1'b0, pat);
    @(posedge clk); #1;
    check("e_ignore_on_done", 32'(bus0.cs), 32'd1);
    bus0.data_bus = pat;
    @(posedge clk); #1;
    bus0.start_spi = 1'b0;
    check("e_accept_cs",   32'(bus0.cs),   32'd0);
    check("e_accept_mosi", 32'(bus0.mosi), 32'd1);
    wait_done(1'b0, 5000, ok);
    check("e_done_seen", 32'(ok), 32'd1);
    frame_check0("e");

    // Frame F: CLK_DIV=1 instance, start held as a level for 10 cycles
    clear1();
    pat = rand_bus();
    push_frame(1'b1, pat);
    start_frame(1'b1, pat, 10);
    wait_done(1'b1, 2000, ok);
    check("f_done_seen", 32'(ok),          32'd1);
    check("f_rises",     32'(rises1),      32'(DW));
    check("f_cs_low",    32'(cs_low1),     32'(CD1 * (2 * DW + 1)));
    check("f_done_cnt",  32'(done1),       32'd1);
    check("f_sb_empty",  32'(q1.size()),   32'd0);
    repeat (600) @(negedge clk);
    check("f_single_frame", 32'(rises1), 32'(DW));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_result_spi_tx.md
Name: fft_result_spi_tx

Overview:
- SPI master transmitter that serializes the 256-bit FFT result bus (16 bins × 16 bits) to an external microcontroller.
- Sits between the FFT core (its `fft_finish` pulse drives `start_spi`) and board pins SCLK/MOSI/CS.
- Mode 0 (CPOL=0, CPHA=0), MSB first, active-low chip select, transmit only.

Parameters:
- DATA_W, 256, total bits per frame; must be a multiple of WORD_W.
- WORD_W, 16, bits per FFT bin word.
- CLK_DIV, 4, system clocks per SCLK half-period; must be ≥1.

Ports:
- clk  in  1  system clock (16 MHz); all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_bus  in  DATA_W  FFT result; bin 0 in [255:240], bin 15 in [15:0].
- start_spi  in  1  single-cycle start pulse.
- sclk  out  1  SPI clock; idles low.
- mosi  out  1  serial data, MSB first.
- cs  out  1  chip select, active low; idles high.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset (async, active-high): cs=1, sclk=0, mosi=0, busy=0, done=0, state=IDLE, shift register and counters cleared.
- States: IDLE, LOW, HIGH, TRAIL. With FFT_SPI_WORD_CS_EN defined, a fifth state GAP is added.
- IDLE:
  - start_spi=1 in cycle N latches data_bus into the shift register.
  - Cycle N+1: cs=0, busy=1, mosi=data_bus[255] (as latched), sclk=0. Enter LOW.
- LOW: sclk=0 for CLK_DIV cycles, then go to HIGH.
- HIGH:
  - sclk=1 for CLK_DIV cycles.
  - At the end, if bits remain: shift left, present the next bit on mosi in the same cycle sclk falls, go to LOW.
  - After the last bit (bit 0): sclk=0, go to TRAIL.
- mosi is stable across each whole rising edge. The receiver samples on the rising sclk edge.
- TRAIL:
  - cs stays low for CLK_DIV cycles.
  - Then cs=1, mosi=0, busy=0, done=1 for exactly one cycle; return to IDLE.
- Frame timing:
  - cs is low for CLK_DIV·(2·DATA_W+1) cycles: 2052 with defaults.
  - Exactly DATA_W rising sclk edges occur per frame.
- Data latching: data_bus is sampled only at the accept cycle. Later changes do not affect the current frame.
- start_spi while busy=1 is ignored; no queueing.
- start_spi in the same cycle done=1 is ignored. The earliest re-accept is the cycle after done.
- start_spi held high for multiple cycles in IDLE is treated as a level: the frame starts once, and start_spi is re-evaluated only after returning to IDLE.
- rst asserted mid-frame aborts immediately: outputs go to reset values, no done pulse.
- Counters:
  - Bit counter is ceil(log2(DATA_W+1)) bits wide; no wrap-around within a frame.
  - Divider counter is ceil(log2(CLK_DIV+1)) bits wide.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- FFT_SPI_WORD_CS_EN defined:
  - After every WORD_W bits except the last word, after the HIGH phase: sclk=0, cs=1 for CLK_DIV cycles (GAP).
  - Then cs=0, present the next word's MSB, and wait CLK_DIV cycles in LOW before the next rising edge.
  - This produces 16 separate cs-low windows per frame, which lets the receiver resync per bin.
- Undefined: a single continuous cs-low window covers the whole frame.

Decomposition:
- Package fft_spi_pkg:
  - Localparams DATA_W_DEF=256, WORD_W_DEF=16, CLK_DIV_DEF=4.
  - State enum type spi_state_t.
- Sub-module spi_clk_div: counts CLK_DIV cycles and emits a one-cycle `phase_tick` when enabled. The main FSM advances only on phase_tick.

Test Plan:
- Reset then idle with no start → cs=1, sclk=0, mosi=0, busy=0 held for 1000 cycles.
- data_bus=256'h8000_0001_..._A5A5 pattern, one start pulse:
  - exactly 256 sclk rising edges;
  - bits captured on rising edges equal data_bus MSB first;
  - cs low 2052 cycles;
  - one done pulse coinciding with cs rise.
- Change data_bus and pulse start_spi mid-frame → captured frame is still the original data; no second frame; one done.
- Assert rst at bit 100 → same cycle cs=1, sclk=0, busy=0; no done. A subsequent start transmits a full correct frame.
- Start pulse on the cycle after done → a second frame begins the next cycle with correct data. CLK_DIV=1 variant: cs low 513 cycles.
- With FFT_SPI_WORD_CS_EN: 16 cs-low windows of 16 rising edges each; cs high CLK_DIV cycles between windows; words match bins 0..15 in order.
